// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and channel identifiers.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_DONE,
      WR_ISSUE,
      WR_WAIT,
      WR_DONE
   } arb_state_t;

   typedef enum logic {
      CH_RD,
      CH_WR
   } chan_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// MCU request channels and the memory-wrapper handshake seen by the arbiter.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_rd_req;
   logic [ADDR_W-1:0] i_rd_addr;
   logic              i_wr_req;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_read_complete;
   logic              o_write_complete;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_ren;
   logic              o_mem_wen;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;
   logic              i_mem_done;
   logic              o_busy;
   logic              o_timeout_err;
   logic              o_overrun_err;

   modport slave (
      input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata, i_mem_done,
      output o_rd_data, o_read_complete, o_write_complete, o_mem_addr, o_mem_ren, o_mem_wen,
             o_mem_wdata, o_busy, o_timeout_err, o_overrun_err
   );

   modport master (
      output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata, i_mem_done,
      input  o_rd_data, o_read_complete, o_write_complete, o_mem_addr, o_mem_ren, o_mem_wen,
             o_mem_wdata, o_busy, o_timeout_err, o_overrun_err
   );
endinterface

// File: rtl/mem_port_arbiter_req_capture.sv
// One request channel: pending flag, address/data latch and overrun detection.
module req_capture #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                                    clk,
   input  logic                                    n_rst,
   input  logic                                    req_i,
   input  logic [ADDR_W-1:0]                       addr_i,
   input  logic [((DATA_W > 0) ? DATA_W : 1)-1:0]  data_i,
   input  logic                                    clr_i,
   output logic                                    pending_o,
   output logic [ADDR_W-1:0]                       addr_o,
   output logic [((DATA_W > 0) ? DATA_W : 1)-1:0]  data_o,
   output logic                                    overrun_o
);
   logic              pend_q, pend_d;
   logic              accept;
   logic [ADDR_W-1:0] addr_q;

   // A completion clearing the flag in the same cycle frees the slot for the new request.
   assign accept    = req_i & (~pend_q | clr_i);
   assign overrun_o = req_i & pend_q & ~clr_i;

   always_comb begin
      pend_d = pend_q;
      if (accept)
         pend_d = 1'b1;
      else if (clr_i)
         pend_d = 1'b0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_q <= 1'b0;
         addr_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (accept)
            addr_q <= addr_i;
      end
   end

   generate
      if (DATA_W > 0) begin : g_data
         logic [DATA_W-1:0] data_q;
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)
               data_q <= '0;
            else if (accept)
               data_q <= data_i;
         end
         assign data_o = data_q;
      end else begin : g_nodata
         // Read channel carries no payload; the tied-off input passes straight through.
         assign data_o = data_i;
      end
   endgenerate

   assign pending_o = pend_q;
   assign addr_o    = addr_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the image-memory port between MCU read and write channels.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input logic               clk,
   input logic               n_rst,
   mem_port_arbiter_if.slave bus
);
   // state    | meaning
   // IDLE     | no access in flight; arbitrate pending channels
   // RD_ISSUE | memory read strobe for one cycle
   // RD_WAIT  | wait for i_mem_done or timeout
   // RD_DONE  | read_complete pulse, clear read pending
   // WR_ISSUE | memory write strobe for one cycle
   // WR_WAIT  | wait for i_mem_done or timeout
   // WR_DONE  | write_complete pulse, clear write pending

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   chan_t             last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              terr_q, terr_d;
   logic              oerr_q;
   logic              ren_q, wen_q, rc_q, wc_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   logic              rd_pend, wr_pend, rd_ovr, wr_ovr, rd_clr, wr_clr;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign rd_clr = (state_q == RD_DONE);
   assign wr_clr = (state_q == WR_DONE);

   req_capture #(.ADDR_W(ADDR_W), .DATA_W(0)) u_rd_cap (
      .clk(clk), .n_rst(n_rst), .req_i(bus.i_rd_req), .addr_i(bus.i_rd_addr), .data_i(1'b0),
      .clr_i(rd_clr), .pending_o(rd_pend), .addr_o(rd_addr), .data_o(), .overrun_o(rd_ovr)
   );

   req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_cap (
      .clk(clk), .n_rst(n_rst), .req_i(bus.i_wr_req), .addr_i(bus.i_wr_addr),
      .data_i(bus.i_wr_data), .clr_i(wr_clr), .pending_o(wr_pend), .addr_o(wr_addr),
      .data_o(wr_data), .overrun_o(wr_ovr)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE: begin
            if (rd_pend && (!wr_pend || last_q == CH_WR)) begin
               state_d = RD_ISSUE;
               last_d  = CH_RD;
            end else if (wr_pend) begin
               state_d = WR_ISSUE;
               last_d  = CH_WR;
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
            cnt_d   = '0;
         end
         WR_ISSUE: begin
            state_d = WR_WAIT;
            cnt_d   = '0;
         end
         RD_WAIT, WR_WAIT: begin
            if (bus.i_mem_done) begin
               state_d = (state_q == RD_WAIT) ? RD_DONE : WR_DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = (state_q == RD_WAIT) ? RD_DONE : WR_DONE;
               terr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_DONE, WR_DONE: state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   // Strobes and pulses are registered from the next state so they coincide with it.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         last_q  <= CH_WR;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
         oerr_q  <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         rc_q    <= 1'b0;
         wc_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
         oerr_q  <= oerr_q | rd_ovr | wr_ovr;
         ren_q   <= (state_d == RD_ISSUE);
         wen_q   <= (state_d == WR_ISSUE);
         rc_q    <= (state_d == RD_DONE);
         wc_q    <= (state_d == WR_DONE);
         if (state_d == RD_ISSUE) begin
            addr_q <= rd_addr;
         end else if (state_d == WR_ISSUE) begin
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
         end
         if (state_q == RD_WAIT && bus.i_mem_done)
            rdata_q <= bus.i_mem_rdata;
      end
   end

   assign bus.o_rd_data        = rdata_q;
   assign bus.o_read_complete  = rc_q;
   assign bus.o_write_complete = wc_q;
   assign bus.o_mem_addr       = addr_q;
   assign bus.o_mem_ren        = ren_q;
   assign bus.o_mem_wen        = wen_q;
   assign bus.o_mem_wdata      = wdata_q;
   assign bus.o_busy           = (state_q != IDLE) | rd_pend | wr_pend;
   assign bus.o_timeout_err    = terr_q;
   assign bus.o_overrun_err    = oerr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected accesses, a monitor checks them.
module tb_mem_port_arbiter;
   localparam int TMO = 8;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          tmo;
   } txn_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   txn_t exp_iss[$];
   txn_t exp_cmpl[$];

   bit          mem_en = 1'b1;
   int          mem_delay = 1;
   logic [31:0] mem_rdata = '0;
   int          done_cyc = 0;
   int          strobe_cyc = 0;
   int          cmpl_cyc = 0;
   int          n_cmpl = 0;

   bit          model_last_wr = 1'b1;
   logic [31:0] model_rd = '0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .n_rst(n_rst), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory wrapper model: answers a strobe with i_mem_done mem_delay cycles later.
   initial begin
      bus.i_mem_done  = 1'b0;
      bus.i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((bus.o_mem_ren || bus.o_mem_wen) && mem_en && n_rst) begin
            repeat (mem_delay) @(negedge clk);
            bus.i_mem_done  = 1'b1;
            bus.i_mem_rdata = mem_rdata;
            done_cyc        = cyc;
            @(negedge clk);
            bus.i_mem_done  = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT strobes memory or signals completion.
   initial begin
      txn_t acc;
      txn_t e;
      bit   in_acc = 1'b0;
      bit   stable_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            in_acc = 1'b0;
         end else begin
            if (bus.o_mem_ren || bus.o_mem_wen) begin
               if (exp_iss.size() == 0) begin
                  chk("unexpected_strobe", {bus.o_mem_ren, bus.o_mem_wen}, 2'b00);
               end else begin
                  e = exp_iss.pop_front();
                  chk("strobe_kind", {bus.o_mem_ren, bus.o_mem_wen}, {!e.is_wr, e.is_wr});
                  chk("issue_addr", bus.o_mem_addr, e.addr);
                  if (e.is_wr) chk("issue_wdata", bus.o_mem_wdata, e.wdata);
                  acc = e;
                  in_acc = 1'b1;
                  stable_ok = 1'b1;
                  strobe_cyc = cyc;
               end
            end else if (in_acc) begin
               if (bus.o_mem_addr !== acc.addr || (acc.is_wr && bus.o_mem_wdata !== acc.wdata))
                  stable_ok = 1'b0;
            end
            if (bus.o_read_complete || bus.o_write_complete) begin
               n_cmpl++;
               cmpl_cyc = cyc;
               if (exp_cmpl.size() == 0) begin
                  chk("unexpected_complete", {bus.o_read_complete, bus.o_write_complete}, 2'b00);
               end else begin
                  e = exp_cmpl.pop_front();
                  chk("complete_kind", {bus.o_read_complete, bus.o_write_complete},
                      {!e.is_wr, e.is_wr});
                  if (!e.is_wr) chk("rd_data", bus.o_rd_data, e.rdata);
                  chk("addr_stable", stable_ok, 1'b1);
                  if (e.tmo) begin
                     chk("timeout_latency", cyc - strobe_cyc, TMO + 1);
                     chk("timeout_err_set", bus.o_timeout_err, 1'b1);
                  end else begin
                     chk("complete_after_done", cyc - done_cyc, 1);
                  end
               end
               in_acc = 1'b0;
            end
         end
      end
   end

   task automatic issue(input bit do_rd, input bit do_wr, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] wd);
      txn_t t_rd;
      txn_t t_wr;
      t_rd = '{is_wr: 1'b0, addr: ra, wdata: '0, rdata: (mem_en ? mem_rdata : model_rd), tmo: !mem_en};
      t_wr = '{is_wr: 1'b1, addr: wa, wdata: wd, rdata: '0, tmo: !mem_en};
      if (do_rd && mem_en) model_rd = mem_rdata;
      // Round robin: with both waiting, the channel not granted last goes first.
      if (do_rd && do_wr) begin
         if (model_last_wr) begin
            exp_iss.push_back(t_rd); exp_cmpl.push_back(t_rd);
            exp_iss.push_back(t_wr); exp_cmpl.push_back(t_wr);
            model_last_wr = 1'b1;
         end else begin
            exp_iss.push_back(t_wr); exp_cmpl.push_back(t_wr);
            exp_iss.push_back(t_rd); exp_cmpl.push_back(t_rd);
            model_last_wr = 1'b0;
         end
      end else if (do_rd) begin
         exp_iss.push_back(t_rd); exp_cmpl.push_back(t_rd);
         model_last_wr = 1'b0;
      end else if (do_wr) begin
         exp_iss.push_back(t_wr); exp_cmpl.push_back(t_wr);
         model_last_wr = 1'b1;
      end
      bus.i_rd_req  = do_rd;
      bus.i_rd_addr = ra;
      bus.i_wr_req  = do_wr;
      bus.i_wr_addr = wa;
      bus.i_wr_data = wd;
      @(negedge clk);
      bus.i_rd_req = 1'b0;
      bus.i_wr_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (bus.o_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, bus.o_busy, 1'b0);
      chk({tag, "_queues_empty"}, exp_iss.size() + exp_cmpl.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ren"}, bus.o_mem_ren, 1'b0);
      chk({tag, "_wen"}, bus.o_mem_wen, 1'b0);
      chk({tag, "_rc"}, bus.o_read_complete, 1'b0);
      chk({tag, "_wc"}, bus.o_write_complete, 1'b0);
      chk({tag, "_addr"}, bus.o_mem_addr, 32'h0);
      chk({tag, "_wdata"}, bus.o_mem_wdata, 32'h0);
      chk({tag, "_rd_data"}, bus.o_rd_data, 32'h0);
      chk({tag, "_busy"}, bus.o_busy, 1'b0);
      chk({tag, "_terr"}, bus.o_timeout_err, 1'b0);
      chk({tag, "_oerr"}, bus.o_overrun_err, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int req_cyc;
      int cnt_before;
      int kind;
      int n;
      bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
      bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      n_rst = 1'b1;
      @(negedge clk);

      mem_delay = 3; mem_rdata = 32'hA5;
      req_cyc = cyc;
      issue(1'b1, 1'b0, 32'h10, '0, '0);
      wait_idle("read_only");
      chk("rd_strobe_latency", strobe_cyc - req_cyc, 2);
      chk("rd_data_held", bus.o_rd_data, 32'hA5);

      mem_delay = 1; mem_rdata = 32'h1234_5678;
      req_cyc = cyc;
      issue(1'b1, 1'b0, 32'h20, '0, '0);
      wait_idle("min_latency");
      chk("min_req_to_complete", cmpl_cyc - req_cyc, 4);

      mem_delay = 2; mem_rdata = 32'h0BAD_F00D;
      issue(1'b1, 1'b1, 32'h100, 32'h200, 32'hCAFE);
      wait_idle("pair1");
      issue(1'b1, 1'b0, 32'h104, '0, '0);
      wait_idle("rr_single");
      issue(1'b1, 1'b1, 32'h108, 32'h208, 32'hBEEF);
      wait_idle("pair2");

      mem_delay = 5;
      issue(1'b0, 1'b1, '0, 32'h258, 32'hDEAD);
      wait_idle("write");

      for (int i = 0; i < 40; i++) begin
         mem_delay = $urandom_range(1, TMO);
         mem_rdata = $urandom;
         kind = $urandom_range(0, 2);
         issue(kind != 1, kind != 0, $urandom, $urandom, $urandom);
         wait_idle("random");
      end
      chk("no_timeout_yet", bus.o_timeout_err, 1'b0);
      chk("no_overrun_yet", bus.o_overrun_err, 1'b0);

      mem_delay = 3; mem_rdata = 32'h0000_0040;
      issue(1'b1, 1'b0, 32'h40, '0, '0);
      bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h44;
      @(negedge clk);
      bus.i_rd_req = 1'b0;
      wait_idle("overrun");
      chk("overrun_err", bus.o_overrun_err, 1'b1);

      mem_en = 1'b0;
      issue(1'b1, 1'b0, 32'h80, '0, '0);
      wait_idle("timeout");
      chk("timeout_rd_data_kept", bus.o_rd_data, 32'h0000_0040);
      repeat (5) @(negedge clk);
      chk("timeout_sticky", bus.o_timeout_err, 1'b1);
      chk("overrun_sticky", bus.o_overrun_err, 1'b1);

      issue(1'b1, 1'b0, 32'h90, '0, '0);
      n = 0;
      while (!bus.o_mem_ren && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_strobe", bus.o_mem_ren, 1'b1);
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      exp_iss.delete();
      exp_cmpl.delete();
      model_last_wr = 1'b1;
      model_rd = '0;
      cnt_before = n_cmpl;
      @(negedge clk);
      n_rst = 1'b1;
      mem_en = 1'b1;
      repeat (15) @(negedge clk);
      chk("no_complete_after_reset", n_cmpl - cnt_before, 0);
      chk("idle_after_reset", bus.o_busy, 1'b0);

      mem_delay = 2; mem_rdata = 32'h5A5A_5A5A;
      issue(1'b1, 1'b1, 32'h300, 32'h400, 32'h77);
      wait_idle("pair_after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
